aip_slave_if: RTL and testbench
===============================

// Module: aip_slave_if
// PURPOSE
//  AIP-side slave interface sitting directly downstream of the host AIP bus driver (config/read/write/start strobes).
//  Decodes 5-bit config codes into an input data memory, an output data memory, a status register and a core ID.
//  Hands a start/done handshake to the attached processing core.
//  The core reads operands from the input memory and writes results into the output memory.
// PARAMETERS
//  MEM_DEPTH   16            words in each of the input and output memories (power of 2, 2..256)
//  DATA_W      32            AIP data width
//  CORE_ID     32'h0000_A1B0 value returned for the ID config code
// PORTS
//  clk         in   1        single clock, all logic rising-edge
//  rst         in   1        synchronous, active-high reset
//  dataInAIP   in   32       write data from host
//  dataOutAIP  out  32       read data to host
//  confAIP     in   5        config code selecting target
//  readAIP     in   1        read strobe (may be held several cycles)
//  writeAIP    in   1        write strobe (may be held several cycles)
//  startAIP    in   1        start strobe (may be held several cycles)
//  intAIP      out  1        interrupt: done & int_en
//  core_start  out  1        one-cycle start pulse to core
//  core_done   in   1        one-cycle completion pulse from core
//  core_raddr  in   log2(MEM_DEPTH)   core read address, input memory
//  core_rdata  out  32       combinational input-memory read data
//  core_we     in   1        core write enable, output memory
//  core_waddr  in   log2(MEM_DEPTH)   core write address, output memory
//  core_wdata  in   32       core write data
// BEHAVIOUR
//  Strobe qualification:
//   - read/write/start act once, on the first cycle a strobe is high (rising edge vs registered copy).
//   - A held strobe performs no further action.
//  Config codes:
//   - 0x00 WR: inmem[wptr] <= dataIn; wptr++.
//   - 0x01 WR: wptr <= dataIn[AW-1:0].
//   - 0x02 RD: returns outmem[rptr]; rptr++ on the qualifying edge.
//   - 0x03 WR: rptr <= dataIn[AW-1:0].
//   - 0x1E RD: STATUS = {29'b0, int_en, busy, done}.
//   - 0x1E WR: int_en <= dataIn[2]; dataIn[0]=1 clears done (write-1-clear).
//   - 0x1F RD: CORE_ID.
//   - Other codes: reads return 0; writes are ignored.
//  dataOutAIP:
//   - Combinational mux of the selected source, valid while readAIP=1.
//   - Drives 0 when readAIP=0.
//   - The registered rptr increment is visible on the next read.
//  Pointers wrap modulo MEM_DEPTH (wptr=15 plus a write -> 0). There is no full/empty flag.
//  FSM with states IDLE, RUN, DONE:
//   - IDLE -> RUN on start edge: core_start=1 for exactly that cycle; done cleared.
//   - RUN  -> DONE on core_done: done=1.
//   - DONE -> IDLE on a W1C write to done.
//   - DONE -> RUN directly on a new start edge.
//   - Start edge in RUN is ignored (no second pulse).
//  busy = (state==RUN).
//  Simultaneous host write to inmem and core read of the same address: core_rdata shows the old value that cycle.
//  Host read of an outmem word that the core writes in the same cycle returns the old value.
//  Reset values: wptr=rptr=0, int_en=0, state=IDLE, done=0, core_start=0, intAIP=0, strobe history=0.
//  Memory contents are not reset.
//  Reset mid-RUN returns to IDLE. A later core_done in IDLE is ignored.
// STRUCTURE
//  Package aip_pkg:
//   - config-code localparams (CFG_WR_INMEM, CFG_WR_INPTR, CFG_RD_OUTMEM, CFG_WR_OUTPTR, CFG_STATUS, CFG_ID).
//   - state enum aip_state_t.
//   - STATUS bit indices.
//  Sub-module aip_dp_mem (1 write port, 1 async read port, no reset):
//   - Instantiated twice: inmem (host W / core R) and outmem (core W / host R).
// TESTING
//  1. Reset, then read 0x1F -> 0x0000A1B0; read 0x1E -> 0; intAIP=0; core_start=0.
//  2. Write 0x01=0, then write 0x00 with 0x11,0x22,0x33 -> core_raddr 0,1,2 give 0x11,0x22,0x33.
//  3. Hold writeAIP 4 cycles on 0x00 with 0x55 -> exactly one word written, wptr advances by 1.
//  4. Write 0x1E=0x4, start edge -> one core_start pulse; STATUS=0x6.
//     Second start during RUN -> no pulse.
//     core_done -> STATUS=0x5, intAIP=1.
//     Write 0x1E=0x5 -> STATUS=0x4, intAIP=0.
//  5. Core writes outmem[0..15]=k*3.
//     Write 0x03=14, then read 0x02 four times -> 42,45,0,3 (wrap).
//  6. rst during RUN -> state IDLE, STATUS=0.
//     Following core_done -> STATUS stays 0, no interrupt.

Source files
------------

// File: rtl/aip_pkg.sv
// Shared config codes, STATUS bit positions and FSM state type for the AIP slave interface.
package aip_pkg;

    localparam logic [4:0] CFG_WR_INMEM  = 5'h00;
    localparam logic [4:0] CFG_WR_INPTR  = 5'h01;
    localparam logic [4:0] CFG_RD_OUTMEM = 5'h02;
    localparam logic [4:0] CFG_WR_OUTPTR = 5'h03;
    localparam logic [4:0] CFG_STATUS    = 5'h1E;
    localparam logic [4:0] CFG_ID        = 5'h1F;

    localparam int unsigned STATUS_DONE   = 0;
    localparam int unsigned STATUS_BUSY   = 1;
    localparam int unsigned STATUS_INT_EN = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } aip_state_t;

endpackage

// File: rtl/aip_dp_mem.sv
// Simple dual-port memory: one synchronous write port, one asynchronous read port, no reset.
module aip_dp_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-during-write returns the pre-write contents.
    assign rdata = mem[raddr];

endmodule

// File: rtl/aip_slave_if.sv
// AIP slave interface: decodes host config/read/write/start strobes into memories, status and
// a start/done handshake with the attached core.
module aip_slave_if
    import aip_pkg::*;
#(
    parameter int unsigned       MEM_DEPTH = 16,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [DATA_W-1:0] CORE_ID   = 32'h0000_A1B0,
    localparam int unsigned      AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dataInAIP,
    output logic [DATA_W-1:0] dataOutAIP,
    input  logic [4:0]        confAIP,
    input  logic              readAIP,
    input  logic              writeAIP,
    input  logic              startAIP,
    output logic              intAIP,
    output logic              core_start,
    input  logic              core_done,
    input  logic [AW-1:0]     core_raddr,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              core_we,
    input  logic [AW-1:0]     core_waddr,
    input  logic [DATA_W-1:0] core_wdata
);

    logic read_q, write_q, start_q;
    logic rd_edge, wr_edge, start_edge;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic int_en_q, int_en_d;
    aip_state_t state_q, state_d;
    logic done, busy, status_w1c, inmem_we;
    logic [DATA_W-1:0] outmem_rdata, status;

    // Strobes act only on the cycle they rise.
    assign rd_edge    = readAIP  & ~read_q;
    assign wr_edge    = writeAIP & ~write_q;
    assign start_edge = startAIP & ~start_q;

    assign done       = (state_q == StDone);
    assign busy       = (state_q == StRun);
    assign inmem_we   = wr_edge && (confAIP == CFG_WR_INMEM);
    assign status_w1c = wr_edge && (confAIP == CFG_STATUS) && dataInAIP[STATUS_DONE];
    assign intAIP     = done & int_en_q;

    always_comb begin
        status                = '0;
        status[STATUS_DONE]   = done;
        status[STATUS_BUSY]   = busy;
        status[STATUS_INT_EN] = int_en_q;
    end

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        int_en_d = int_en_q;
        if (wr_edge) begin
            case (confAIP)
                CFG_WR_INMEM:  wptr_d   = wptr_q + AW'(1);
                CFG_WR_INPTR:  wptr_d   = dataInAIP[AW-1:0];
                CFG_WR_OUTPTR: rptr_d   = dataInAIP[AW-1:0];
                CFG_STATUS:    int_en_d = dataInAIP[STATUS_INT_EN];
                default:       ;
            endcase
        end
        if (rd_edge && (confAIP == CFG_RD_OUTMEM)) begin
            rptr_d = rptr_q + AW'(1);
        end
    end

    always_comb begin
        dataOutAIP = '0;
        if (readAIP) begin
            case (confAIP)
                CFG_RD_OUTMEM: dataOutAIP = outmem_rdata;
                CFG_STATUS:    dataOutAIP = status;
                CFG_ID:        dataOutAIP = CORE_ID;
                default:       dataOutAIP = '0;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_edge) begin
                    state_d    = StRun;
                    core_start = 1'b1;
                end
            end
            StRun: begin
                if (core_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start_edge) begin
                    state_d    = StRun;
                    core_start = 1'b1;
                end else if (status_w1c) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) begin
            core_start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            start_q  <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            int_en_q <= 1'b0;
            state_q  <= StIdle;
        end else begin
            read_q   <= readAIP;
            write_q  <= writeAIP;
            start_q  <= startAIP;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            int_en_q <= int_en_d;
            state_q  <= state_d;
        end
    end

    aip_dp_mem #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_W)
    ) u_inmem (
        .clk   (clk),
        .we    (inmem_we),
        .waddr (wptr_q),
        .wdata (dataInAIP),
        .raddr (core_raddr),
        .rdata (core_rdata)
    );

    aip_dp_mem #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_W)
    ) u_outmem (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .raddr (rptr_q),
        .rdata (outmem_rdata)
    );

endmodule

// File: tb/tb_aip_slave_if.sv
// Self-checking bench for aip_slave_if: vector table for register reads plus directed sequences.
module tb_aip_slave_if;

    localparam int unsigned AW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dataInAIP = '0;
    logic [31:0] dataOutAIP;
    logic [4:0]  confAIP = '0;
    logic        readAIP = 1'b0;
    logic        writeAIP = 1'b0;
    logic        startAIP = 1'b0;
    logic        intAIP;
    logic        core_start;
    logic        core_done = 1'b0;
    logic [AW-1:0] core_raddr = '0;
    logic [31:0] core_rdata;
    logic        core_we = 1'b0;
    logic [AW-1:0] core_waddr = '0;
    logic [31:0] core_wdata = '0;

    int total = 0;
    int bad = 0;
    int start_pulses = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [4:0]  conf;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[4];

    aip_slave_if dut (
        .clk        (clk),
        .rst        (rst),
        .dataInAIP  (dataInAIP),
        .dataOutAIP (dataOutAIP),
        .confAIP    (confAIP),
        .readAIP    (readAIP),
        .writeAIP   (writeAIP),
        .startAIP   (startAIP),
        .intAIP     (intAIP),
        .core_start (core_start),
        .core_done  (core_done),
        .core_raddr (core_raddr),
        .core_rdata (core_rdata),
        .core_we    (core_we),
        .core_waddr (core_waddr),
        .core_wdata (core_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start === 1'b1) start_pulses <= start_pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [4:0] c, input logic [31:0] d);
        @(negedge clk);
        confAIP = c;
        dataInAIP = d;
        writeAIP = 1'b1;
        @(negedge clk);
        writeAIP = 1'b0;
    endtask

    // Expected value is queued when the read is issued and popped when the output is sampled.
    task automatic host_read(input logic [4:0] c, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        @(negedge clk);
        confAIP = c;
        readAIP = 1'b1;
        #1;
        check(name, dataOutAIP, exp_q.pop_front());
        @(negedge clk);
        readAIP = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        startAIP = 1'b1;
        @(negedge clk);
        startAIP = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    initial begin
        int p0;
        vecs[0] = '{conf: 5'h1F, exp: 32'h0000_A1B0};
        vecs[1] = '{conf: 5'h1E, exp: 32'h0};
        vecs[2] = '{conf: 5'h05, exp: 32'h0};
        vecs[3] = '{conf: 5'h1D, exp: 32'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and register decode
        check("rst_int", {31'b0, intAIP}, 32'h0);
        check("rst_core_start", {31'b0, core_start}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            host_read(vecs[i].conf, vecs[i].exp, $sformatf("vec%0d", i));
        end
        @(negedge clk);
        confAIP = 5'h1F;
        #1;
        check("idle_out_zero", dataOutAIP, 32'h0);

        // Input memory fill through write pointer
        host_write(5'h01, 32'h0);
        host_write(5'h00, 32'h11);
        host_write(5'h00, 32'h22);
        host_write(5'h00, 32'h33);
        for (int i = 0; i < 3; i++) begin
            core_raddr = AW'(i);
            #1;
            check($sformatf("inmem%0d", i), core_rdata, 32'h11 * (i + 1));
        end

        // Held write strobe writes exactly once
        @(negedge clk);
        confAIP = 5'h00;
        dataInAIP = 32'h55;
        writeAIP = 1'b1;
        repeat (4) @(negedge clk);
        writeAIP = 1'b0;
        host_write(5'h00, 32'h66);
        core_raddr = 4'd3;
        #1;
        check("held_wr_word", core_rdata, 32'h55);
        core_raddr = 4'd4;
        #1;
        check("held_wr_ptr", core_rdata, 32'h66);

        // Same-cycle host write and core read of one address
        host_write(5'h01, 32'h5);
        host_write(5'h00, 32'hAA);
        host_write(5'h01, 32'h5);
        @(negedge clk);
        confAIP = 5'h00;
        dataInAIP = 32'hBB;
        writeAIP = 1'b1;
        core_raddr = 4'd5;
        #1;
        check("rdw_old", core_rdata, 32'hAA);
        @(posedge clk);
        #1;
        check("rdw_new", core_rdata, 32'hBB);
        @(negedge clk);
        writeAIP = 1'b0;

        // Start/done handshake
        host_write(5'h1E, 32'h4);
        p0 = start_pulses;
        @(negedge clk);
        startAIP = 1'b1;
        #1;
        check("start_pulse", {31'b0, core_start}, 32'h1);
        @(negedge clk);
        #1;
        check("start_held", {31'b0, core_start}, 32'h0);
        @(negedge clk);
        startAIP = 1'b0;
        check("pulse_count1", start_pulses - p0, 32'd1);
        host_read(5'h1E, 32'h6, "status_run");
        pulse_start();
        check("no_restart", start_pulses - p0, 32'd1);
        pulse_done();
        host_read(5'h1E, 32'h5, "status_done");
        check("int_set", {31'b0, intAIP}, 32'h1);
        host_write(5'h1E, 32'h5);
        host_read(5'h1E, 32'h4, "status_w1c");
        check("int_clr", {31'b0, intAIP}, 32'h0);

        // Output memory read-back with pointer wrap
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            core_we = 1'b1;
            core_waddr = AW'(k);
            core_wdata = 32'(k * 3);
        end
        @(negedge clk);
        core_we = 1'b0;
        host_write(5'h03, 32'd14);
        host_read(5'h02, 32'd42, "outmem14");
        host_read(5'h02, 32'd45, "outmem15");
        host_read(5'h02, 32'd0, "outmem_wrap0");
        host_read(5'h02, 32'd3, "outmem_wrap1");

        // Reset in RUN, then a stray done
        pulse_start();
        host_read(5'h1E, 32'h6, "status_run2");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        host_read(5'h1E, 32'h0, "status_after_rst");
        pulse_done();
        host_read(5'h1E, 32'h0, "status_stray_done");
        check("int_stray_done", {31'b0, intAIP}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
